// File: rtl/veda_mem_arbiter.sv
// veda_mem_arbiter: shares one single-port memory between instruction fetch
// and the load/store unit, one access per cycle, with read-data routing.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   if_req/if_addr  fetch request (held until if_gnt), word address
//   if_gnt          fetch access issued on mem_* this cycle
//   if_rvalid/rdata fetch read response, MEM_LAT cycles after if_gnt
//   dm_req/we/addr  data request (held until dm_gnt), store flag, address
//   dm_wdata        store data
//   dm_lock         keep data-port ownership after the current grant
//   dm_gnt          data access issued on mem_* this cycle
//   dm_rvalid/rdata load response, MEM_LAT cycles after dm_gnt
//   mem_en/we       memory strobe and write enable
//   mem_addr/wdata  memory address and write data
//   mem_rdata       memory read data, MEM_LAT cycles after a read strobe

module veda_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_lock,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAST = MEM_LAT - 1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_DM
    } tag_e;

    state_e            state_q;
    // 1 when the data port won the last arbitration
    logic              rr_dm_q;
    tag_e              tag_q [MEM_LAT];
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              if_win;
    logic              dm_win;
    tag_e              issue_tag;

    // ------------------------------------------------------------
    // Arbitration (combinational, suppressed during reset)
    // ------------------------------------------------------------
    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                dm_win = dm_req;
            end else if (if_req && dm_req) begin
                // round robin: the port that did not win last time
                if_win = rr_dm_q;
                dm_win = !rr_dm_q;
            end else begin
                if_win = if_req;
                dm_win = dm_req;
            end
        end
    end

    assign if_gnt = if_win;
    assign dm_gnt = dm_win;

    // ------------------------------------------------------------
    // Memory request mux
    // ------------------------------------------------------------
    always_comb begin
        mem_en    = if_win | dm_win;
        mem_we    = dm_win & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_win) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_win) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        issue_tag = TAG_NONE;
        if (if_win)
            issue_tag = TAG_IF;
        else if (dm_win && !dm_we)
            issue_tag = TAG_DM;
    end

    // ------------------------------------------------------------
    // Lock FSM, round-robin pointer, tag pipeline, read data hold
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OPEN;
            rr_dm_q    <= 1'b1;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            for (int i = 0; i < MEM_LAT; i++)
                tag_q[i] <= TAG_NONE;
        end else begin
            unique case (state_q)
                ST_OPEN: begin
                    if (if_win)
                        rr_dm_q <= 1'b0;
                    if (dm_win) begin
                        rr_dm_q <= 1'b1;
                        // lock only takes hold once data actually owns the port
                        if (dm_lock)
                            state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // a final grant issued with dm_lock low still unlocks
                    if (!dm_lock) begin
                        state_q <= ST_OPEN;
                        rr_dm_q <= 1'b1;
                    end
                end
            endcase

            tag_q[0] <= issue_tag;
            for (int i = 1; i < MEM_LAT; i++)
                tag_q[i] <= tag_q[i-1];

            // capture the returning word so rdata holds after rvalid
            if (tag_q[LAST] == TAG_IF)
                if_rdata_q <= mem_rdata;
            if (tag_q[LAST] == TAG_DM)
                dm_rdata_q <= mem_rdata;
        end
    end

    // ------------------------------------------------------------
    // Read return: the tag in the last stage matches the word now on
    // mem_rdata, so it is forwarded straight through in that cycle to
    // keep grant-to-rvalid at exactly MEM_LAT.
    // ------------------------------------------------------------
    assign if_rvalid = !rst && (tag_q[LAST] == TAG_IF);
    assign dm_rvalid = !rst && (tag_q[LAST] == TAG_DM);

    assign if_rdata = rst       ? '0        :
                      if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata = rst       ? '0        :
                      dm_rvalid ? mem_rdata : dm_rdata_q;

endmodule

// File: doc/veda_mem_arbiter.md
Name: veda_mem_arbiter

Overview:
- Arbitrates the single-port 1024x32 unified instruction/data memory between two requesters: instruction fetch (read-only) and the load/store unit (lw/sw).
- Issues at most one memory access per cycle.
- Tracks in-flight reads through a MEM_LAT-deep tag pipeline so read data returns to the correct requester.
- Supports a data-port lock, so a lw/lw/sw/sw swap sequence runs without interleaved fetches.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles (legal 1 or 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch access issued this cycle
if_rvalid  output  1  if_rdata valid
if_rdata  output  DATA_W  fetch read data
dm_req  input  1  data request; held with dm_we/addr/wdata until dm_gnt
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data word address
dm_wdata  input  DATA_W  store data
dm_lock  input  1  hold data-port ownership after the current grant
dm_gnt  output  1  data access issued this cycle
dm_rvalid  output  1  dm_rdata valid (loads only)
dm_rdata  output  DATA_W  load data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, MEM_LAT cycles after mem_en with mem_we=0

Behaviour:
- Reset values: if_gnt, dm_gnt, mem_en, mem_we, if_rvalid and dm_rvalid are 0; rdata outputs and mem_addr/mem_wdata are 0. rr_last is set to DATA, so fetch wins the first contention. The lock state is cleared.
- Grants and memory outputs are combinational from the requests and registered state, and are forced to 0 while rst=1.
- A grant means the access is presented on the mem_* outputs in that same cycle. The requester drops or changes its request on the cycle after the grant.

Arbitration states:
- OPEN:
  - Only one requester pending: it is granted.
  - Both pending: the one not equal to rr_last is granted.
  - rr_last updates to the winner.
  - A dm grant with dm_lock=1 moves the state to LOCKED.
- LOCKED:
  - The fetch port is never granted.
  - dm_req is granted every cycle it is asserted.
  - When dm_lock=0 and no dm access is granted that cycle, the state returns to OPEN at the next edge, with rr_last=DATA.
  - dm_lock deassert together with a final dm grant: that access issues, and the state returns to OPEN next cycle.

Read return:
- Each issued read pushes a tag (IF or DM) into a MEM_LAT-stage shift register; writes push "none".
- When a tag leaves the last stage, the matching rvalid is pulsed for one cycle and rdata is registered from mem_rdata.
- Total latency from grant to rvalid is MEM_LAT cycles. rdata holds its last value otherwise.
- Back-to-back reads are allowed every cycle. Responses return in issue order.

Memory outputs:
- mem_we = dm_we only when dm is granted. Fetch grants always read.
- mem_addr and mem_wdata come from the winner. With no grant, mem_en=0 and the other mem_* outputs are don't-care but driven to 0.

Boundary conditions:
- Store then load to the same address on consecutive cycles: ordering is preserved. The load returns the stored data, because the memory is single-port with in-order issue.
- Address range: full ADDR_W range, no wrap logic; address is passed through unchanged.
- dm_lock asserted while the state is OPEN and fetch wins: lock takes effect only from the first dm grant.
- Reset mid-operation: the tag pipeline is cleared, and no rvalid is asserted for accesses issued before reset.
- Fetch starvation while LOCKED is permitted by design.

Test Plan:
- Only fetch requests, addr 10..13 on consecutive cycles, MEM_LAT=1 -> if_gnt=1 every cycle; if_rvalid one cycle after each grant with mem[10..13] in order; dm_rvalid stays 0.
- Both requests held after reset, fetch addr 14, load addr 0 (mem[0]=12) -> grant order IF, DM, IF, DM. Each grant is issued at the requester's address (14 / 0), and dm_rdata=12 arrives one cycle after the dm grant.
- dm_lock=1 with sequence lw 3, lw 4, sw 3=32, sw 4=30 while fetch is continuously requesting -> no if_gnt from the first dm grant until the cycle after the dm_lock=0 final store. mem[3]=32, mem[4]=30.
- Store addr 5=99 immediately followed by load addr 5 -> dm_rdata=99.
- MEM_LAT=2, interleaved IF/DM reads -> each rvalid two cycles after its grant, routed to the correct port, no drops.
- rst pulsed one cycle after a fetch read is granted -> no if_rvalid afterwards; all outputs 0 during reset; the first post-reset contention is won by fetch.
